store_data_issue_queue: RTL and testbench

- Compacting issue queue that holds store-data uops until their source register value is available, then issues them one per cycle, oldest-ready first.
- Sits between rename/dispatch and the store-data lookup stage, which reads the register file and forwards data to the store queue.
- Handles wakeup from result-bus broadcasts, and squashes on branch mispredict by store sequence number.

---
 rtl/store_data_issue_queue_if.sv | 38 +++
 rtl/store_data_issue_queue.sv | 171 +++++++++++++++++
 tb/tb_store_data_issue_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_data_issue_queue_if.sv
// Dispatch-side, wakeup, branch and issue signals of the store-data issue queue.
// The slave modport is the queue; the master modport is whoever drives it.
interface store_data_issue_queue_if #(
    parameter int TAG_W  = 7,
    parameter int SQN_W  = 7,
    parameter int NUM_WB = 4
);
    logic                        IN_brTaken;
    logic                        IN_brFlush;
    logic [SQN_W-1:0]            IN_brStoreSqN;
    logic                        IN_enqValid;
    logic                        OUT_enqReady;
    logic [TAG_W-1:0]            IN_enqTag;
    logic [SQN_W-1:0]            IN_enqStoreSqN;
    logic [1:0]                  IN_enqOffs;
    logic                        IN_enqAvail;
    logic [NUM_WB-1:0]           IN_wbValid;
    logic [NUM_WB*(TAG_W-1)-1:0] IN_wbTag;
    logic                        OUT_valid;
    logic                        IN_outReady;
    logic [TAG_W-1:0]            OUT_tag;
    logic [SQN_W-1:0]            OUT_storeSqN;
    logic [1:0]                  OUT_offs;

    modport master (
        output IN_brTaken, IN_brFlush, IN_brStoreSqN,
        output IN_enqValid, IN_enqTag, IN_enqStoreSqN, IN_enqOffs, IN_enqAvail,
        output IN_wbValid, IN_wbTag, IN_outReady,
        input  OUT_enqReady, OUT_valid, OUT_tag, OUT_storeSqN, OUT_offs
    );

    modport slave (
        input  IN_brTaken, IN_brFlush, IN_brStoreSqN,
        input  IN_enqValid, IN_enqTag, IN_enqStoreSqN, IN_enqOffs, IN_enqAvail,
        input  IN_wbValid, IN_wbTag, IN_outReady,
        output OUT_enqReady, OUT_valid, OUT_tag, OUT_storeSqN, OUT_offs
    );
endinterface

// File: rtl/store_data_issue_queue.sv
// Compacting issue queue for store-data uops: waits for the source value,
// issues oldest-ready first into a single output register, squashes by store sqn.
module store_data_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 7,
    parameter int SQN_W  = 7,
    parameter int NUM_WB = 4
) (
    input logic                     clk,
    input logic                     rst,
    store_data_issue_queue_if.slave io
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [SQN_W-1:0] sqn_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] avail_q, avail_d;
    tag_t             tag_q  [DEPTH];
    tag_t             tag_d  [DEPTH];
    sqn_t             sqn_q  [DEPTH];
    sqn_t             sqn_d  [DEPTH];
    logic [1:0]       offs_q [DEPTH];
    logic [1:0]       offs_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    logic             out_valid_q, out_valid_d;
    tag_t             out_tag_q, out_tag_d;
    sqn_t             out_sqn_q, out_sqn_d;
    logic [1:0]       out_offs_q, out_offs_d;

    logic [DEPTH-1:0] keep;
    logic [DEPTH-1:0] wake;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             load;
    logic             out_kill;
    logic             enq_fire;
    logic             enq_avail;

    // Wrapping sqn difference read as signed: positive means a is younger than b.
    function automatic logic younger(input sqn_t a, input sqn_t b);
        sqn_t diff;
        diff = a - b;
        return !diff[SQN_W-1] && (diff != '0);
    endfunction

    always_comb begin
        int wr;
        keep      = '0;
        wake      = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        enq_avail = io.IN_enqAvail | io.IN_enqTag[TAG_W-1];
        valid_d   = '0;
        avail_d   = '0;
        tag_d     = tag_q;
        sqn_d     = sqn_q;
        offs_d    = offs_q;
        wr        = 0;

        for (int i = 0; i < DEPTH; i++) begin
            keep[i] = valid_q[i] && !(io.IN_brTaken &&
                      (io.IN_brFlush || younger(sqn_q[i], io.IN_brStoreSqN)));
            for (int k = 0; k < NUM_WB; k++) begin
                if (io.IN_wbValid[k] && !tag_q[i][TAG_W-1] &&
                    io.IN_wbTag[k*(TAG_W-1) +: (TAG_W-1)] == tag_q[i][TAG_W-2:0])
                    wake[i] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_WB; k++) begin
            if (io.IN_wbValid[k] &&
                io.IN_wbTag[k*(TAG_W-1) +: (TAG_W-1)] == io.IN_enqTag[TAG_W-2:0])
                enq_avail = 1'b1;
        end

        // Select runs on kill-masked entries so a squashed uop never issues.
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && keep[i] && avail_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end

        load     = sel_found && (!out_valid_q || io.IN_outReady);
        out_kill = io.IN_brTaken && (io.IN_brFlush || younger(out_sqn_q, io.IN_brStoreSqN));
        enq_fire = io.IN_enqValid && (count_q < DEPTH_C) &&
                   !(io.IN_brTaken && (io.IN_brFlush ||
                     younger(io.IN_enqStoreSqN, io.IN_brStoreSqN)));

        for (int i = 0; i < DEPTH; i++) begin
            if (keep[i] && !(load && IDX_W'(i) == sel_idx)) begin
                valid_d[IDX_W'(wr)] = 1'b1;
                avail_d[IDX_W'(wr)] = avail_q[i] | wake[i];
                tag_d[IDX_W'(wr)]   = tag_q[i];
                sqn_d[IDX_W'(wr)]   = sqn_q[i];
                offs_d[IDX_W'(wr)]  = offs_q[i];
                wr = wr + 1;
            end
        end

        // A free slot is guaranteed here because the accept test used the registered count.
        if (enq_fire) begin
            valid_d[IDX_W'(wr)] = 1'b1;
            avail_d[IDX_W'(wr)] = enq_avail;
            tag_d[IDX_W'(wr)]   = io.IN_enqTag;
            sqn_d[IDX_W'(wr)]   = io.IN_enqStoreSqN;
            offs_d[IDX_W'(wr)]  = io.IN_enqOffs;
        end
        count_d = CNT_W'(wr) + {{(CNT_W-1){1'b0}}, enq_fire};

        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_sqn_d   = out_sqn_q;
        out_offs_d  = out_offs_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_tag_d   = tag_q[sel_idx];
            out_sqn_d   = sqn_q[sel_idx];
            out_offs_d  = offs_q[sel_idx];
        end else if ((out_valid_q && io.IN_outReady) || out_kill) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        avail_q    <= avail_d;
        tag_q      <= tag_d;
        sqn_q      <= sqn_d;
        offs_q     <= offs_d;
        out_tag_q  <= out_tag_d;
        out_sqn_q  <= out_sqn_d;
        out_offs_q <= out_offs_d;
    end

    assign io.OUT_enqReady = (count_q < DEPTH_C);
    assign io.OUT_valid    = out_valid_q;
    assign io.OUT_tag      = out_tag_q;
    assign io.OUT_storeSqN = out_sqn_q;
    assign io.OUT_offs     = out_offs_q;

    logic valid_ok;
    always_comb begin
        valid_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] != (CNT_W'(i) < count_q))
                valid_ok = 1'b0;
        end
    end

    a_count_le_depth: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
    a_contiguous:     assert property (@(posedge clk) disable iff (rst) valid_ok);
    a_stable_payload: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !io.IN_outReady) |=>
            ($stable(out_tag_q) && $stable(out_sqn_q) && $stable(out_offs_q)));
endmodule

// File: tb/tb_store_data_issue_queue.sv
// Bench for store_data_issue_queue: directed scenarios with fixed expectations,
// then random traffic compared against a queue-based reference model.
module tb_store_data_issue_queue;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 7;
    localparam int SQN_W  = 7;
    localparam int NUM_WB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    store_data_issue_queue_if #(.TAG_W(TAG_W), .SQN_W(SQN_W), .NUM_WB(NUM_WB)) io();

    store_data_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .SQN_W(SQN_W), .NUM_WB(NUM_WB)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [SQN_W-1:0] sqn;
        logic [1:0]       offs;
        bit               avail;
    } ent_t;

    ent_t mq[$];
    bit   m_out_v;
    ent_t m_out;

    // Signed distance a-b on a 2^SQN_W circle, positive when a is younger.
    function automatic bit m_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        int diff;
        diff = (int'(a) - int'(b) + 2 * (1 << SQN_W)) % (1 << SQN_W);
        if (diff >= (1 << (SQN_W - 1))) diff = diff - (1 << SQN_W);
        return diff > 0;
    endfunction

    function automatic bit m_wb_hit(input logic [TAG_W-1:0] tag);
        for (int k = 0; k < NUM_WB; k++)
            if (io.IN_wbValid[k] && io.IN_wbTag[k*(TAG_W-1) +: (TAG_W-1)] == tag[TAG_W-2:0])
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int   idx;
        bit   can_load;
        bit   enq_ok;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_out_v = 1'b0;
            return;
        end
        can_load = !m_out_v || io.IN_outReady;
        enq_ok   = io.IN_enqValid && (mq.size() < DEPTH);
        if (m_out_v && io.IN_outReady) m_out_v = 1'b0;
        if (io.IN_brTaken) begin
            if (io.IN_brFlush) begin
                mq.delete();
                m_out_v = 1'b0;
                enq_ok  = 1'b0;
            end else begin
                for (int i = mq.size() - 1; i >= 0; i--)
                    if (m_younger(mq[i].sqn, io.IN_brStoreSqN)) mq.delete(i);
                if (m_out_v && m_younger(m_out.sqn, io.IN_brStoreSqN)) m_out_v = 1'b0;
                if (m_younger(io.IN_enqStoreSqN, io.IN_brStoreSqN)) enq_ok = 1'b0;
            end
        end
        idx = -1;
        for (int i = 0; i < mq.size(); i++)
            if (idx < 0 && mq[i].avail) idx = i;
        if (can_load && idx >= 0) begin
            m_out   = mq[idx];
            m_out_v = 1'b1;
            mq.delete(idx);
        end
        for (int i = 0; i < mq.size(); i++)
            if (m_wb_hit(mq[i].tag)) mq[i].avail = 1'b1;
        if (enq_ok) begin
            e.tag   = io.IN_enqTag;
            e.sqn   = io.IN_enqStoreSqN;
            e.offs  = io.IN_enqOffs;
            e.avail = io.IN_enqAvail || io.IN_enqTag[TAG_W-1] || m_wb_hit(io.IN_enqTag);
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        io.IN_brTaken     = 1'b0;
        io.IN_brFlush     = 1'b0;
        io.IN_brStoreSqN  = '0;
        io.IN_enqValid    = 1'b0;
        io.IN_enqTag      = '0;
        io.IN_enqStoreSqN = '0;
        io.IN_enqOffs     = '0;
        io.IN_enqAvail    = 1'b0;
        io.IN_wbValid     = '0;
        io.IN_wbTag       = '0;
    endtask

    task automatic enq(input logic [TAG_W-1:0] tag, input logic [SQN_W-1:0] sqn,
                       input logic [1:0] offs, input logic avail);
        io.IN_enqValid    = 1'b1;
        io.IN_enqTag      = tag;
        io.IN_enqStoreSqN = sqn;
        io.IN_enqOffs     = offs;
        io.IN_enqAvail    = avail;
    endtask

    task automatic test_reset();
        idle_inputs();
        io.IN_outReady = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (io.OUT_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", io.OUT_valid);
        end
        checks++;
        if (io.OUT_enqReady !== 1'b1) begin
            errors++; $display("FAIL reset_enq_ready: got %b expected 1", io.OUT_enqReady);
        end
    endtask

    task automatic test_immediate();
        enq(7'h45, 7'd3, 2'd1, 1'b0);
        tick();
        idle_inputs();
        checks++;
        if (io.OUT_valid !== 1'b0 || io.OUT_enqReady !== 1'b1) begin
            errors++; $display("FAIL imm_stage1: valid=%b ready=%b expected 0/1", io.OUT_valid, io.OUT_enqReady);
        end
        tick();
        checks++;
        if (io.OUT_valid !== 1'b1 || io.OUT_tag !== 7'h45 || io.OUT_storeSqN !== 7'd3 || io.OUT_offs !== 2'd1) begin
            errors++; $display("FAIL imm_issue: valid=%b tag=%h sqn=%0d offs=%0d expected 1/45/3/1",
                               io.OUT_valid, io.OUT_tag, io.OUT_storeSqN, io.OUT_offs);
        end
        checks++;
        if (io.OUT_enqReady !== 1'b1) begin
            errors++; $display("FAIL imm_ready: got %b expected 1", io.OUT_enqReady);
        end
        tick();
        checks++;
        if (io.OUT_valid !== 1'b0) begin
            errors++; $display("FAIL imm_drain: got %b expected 0", io.OUT_valid);
        end
    endtask

    task automatic test_wakeup_order();
        enq(7'h05, 7'd1, 2'd0, 1'b0);
        tick();
        enq(7'h06, 7'd2, 2'd2, 1'b1);
        tick();
        idle_inputs();
        tick();
        checks++;
        if (io.OUT_valid !== 1'b1 || io.OUT_storeSqN !== 7'd2 || io.OUT_tag !== 7'h06) begin
            errors++; $display("FAIL wake_first: valid=%b sqn=%0d tag=%h expected 1/2/06",
                               io.OUT_valid, io.OUT_storeSqN, io.OUT_tag);
        end
        io.IN_wbValid = 4'b0100;
        io.IN_wbTag   = 24'(6'h05) << 12;
        tick();
        idle_inputs();
        checks++;
        if (io.OUT_valid !== 1'b0) begin
            errors++; $display("FAIL wake_gap: got %b expected 0", io.OUT_valid);
        end
        tick();
        checks++;
        if (io.OUT_valid !== 1'b1 || io.OUT_storeSqN !== 7'd1 || io.OUT_tag !== 7'h05) begin
            errors++; $display("FAIL wake_second: valid=%b sqn=%0d tag=%h expected 1/1/05",
                               io.OUT_valid, io.OUT_storeSqN, io.OUT_tag);
        end
        tick();
        checks++;
        if (io.OUT_valid !== 1'b0 || io.OUT_enqReady !== 1'b1) begin
            errors++; $display("FAIL wake_empty: valid=%b ready=%b expected 0/1", io.OUT_valid, io.OUT_enqReady);
        end
    endtask

    task automatic test_full();
        io.IN_outReady = 1'b0;
        for (int k = 0; k < 9; k++) begin
            enq(7'h40 | 7'(k), 7'(20 + k), 2'(k), 1'b1);
            tick();
            checks++;
            if (io.OUT_enqReady !== (k < 8)) begin
                errors++; $display("FAIL full_ready_%0d: got %b expected %b", k, io.OUT_enqReady, (k < 8));
            end
        end
        enq(7'h7f, 7'd29, 2'd3, 1'b1);
        tick();
        idle_inputs();
        checks++;
        if (io.OUT_enqReady !== 1'b0 || io.OUT_valid !== 1'b1 || io.OUT_storeSqN !== 7'd20) begin
            errors++; $display("FAIL full_hold: ready=%b valid=%b sqn=%0d expected 0/1/20",
                               io.OUT_enqReady, io.OUT_valid, io.OUT_storeSqN);
        end
        io.IN_outReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (io.OUT_valid !== 1'b1 || io.OUT_storeSqN !== 7'(21 + k) || io.OUT_enqReady !== 1'b1) begin
                errors++; $display("FAIL full_drain_%0d: valid=%b sqn=%0d ready=%b expected 1/%0d/1",
                                   k, io.OUT_valid, io.OUT_storeSqN, io.OUT_enqReady, 21 + k);
            end
        end
        tick();
        checks++;
        if (io.OUT_valid !== 1'b0) begin
            errors++; $display("FAIL full_empty: got %b expected 0 (sqn %0d leaked)", io.OUT_valid, io.OUT_storeSqN);
        end
    endtask

    // Loads out register with the first sqn, queues the rest, applies a non-flush branch, drains.
    task automatic run_branch(input string name, input int sqns[$], input logic [SQN_W-1:0] br_sqn,
                              input int survivors[$]);
        io.IN_outReady = 1'b0;
        foreach (sqns[k]) begin
            enq(7'h40 | 7'(k), 7'(sqns[k]), 2'(k), 1'b1);
            tick();
        end
        idle_inputs();
        io.IN_brTaken    = 1'b1;
        io.IN_brStoreSqN = br_sqn;
        enq(7'h41, br_sqn + 7'd3, 2'd0, 1'b1);
        tick();
        idle_inputs();
        io.IN_outReady = 1'b1;
        foreach (survivors[k]) begin
            checks++;
            if (io.OUT_valid !== 1'b1 || io.OUT_storeSqN !== 7'(survivors[k])) begin
                errors++; $display("FAIL %s_issue_%0d: valid=%b sqn=%0d expected 1/%0d",
                                   name, k, io.OUT_valid, io.OUT_storeSqN, survivors[k]);
            end
            tick();
        end
        checks++;
        if (io.OUT_valid !== 1'b0) begin
            errors++; $display("FAIL %s_empty: valid=%b sqn=%0d expected valid 0", name, io.OUT_valid, io.OUT_storeSqN);
        end
    endtask

    task automatic test_branch_kill();
        run_branch("brkill", '{9, 10, 11, 12, 13}, 7'd11, '{9, 10, 11});
    endtask

    task automatic test_wraparound();
        run_branch("wrap", '{125, 126, 127, 0}, 7'd127, '{125, 126, 127});
    endtask

    task automatic test_flush();
        io.IN_outReady = 1'b0;
        for (int k = 0; k < 9; k++) begin
            enq(7'h40, 7'(40 + k), 2'd0, 1'b1);
            tick();
        end
        checks++;
        if (io.OUT_enqReady !== 1'b0 || io.OUT_valid !== 1'b1) begin
            errors++; $display("FAIL flush_pre: ready=%b valid=%b expected 0/1", io.OUT_enqReady, io.OUT_valid);
        end
        io.IN_brTaken  = 1'b1;
        io.IN_brFlush  = 1'b1;
        io.IN_brStoreSqN = 7'd60;
        enq(7'h40, 7'd49, 2'd0, 1'b1);
        tick();
        idle_inputs();
        checks++;
        if (io.OUT_valid !== 1'b0 || io.OUT_enqReady !== 1'b1) begin
            errors++; $display("FAIL flush_post: valid=%b ready=%b expected 0/1", io.OUT_valid, io.OUT_enqReady);
        end
        io.IN_outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (io.OUT_valid !== 1'b0) begin
                errors++; $display("FAIL flush_residue_%0d: valid=%b sqn=%0d expected 0", k, io.OUT_valid, io.OUT_storeSqN);
            end
        end
    endtask

    task automatic test_random();
        logic [SQN_W-1:0] next_sqn;
        next_sqn = 7'd100;
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            io.IN_outReady = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 60) begin
                enq({1'($urandom_range(0, 3) == 0), 6'($urandom_range(0, 7))}, next_sqn,
                    2'($urandom_range(0, 3)), ($urandom_range(0, 99) < 25));
                if (io.OUT_enqReady) next_sqn = next_sqn + 7'd1;
            end
            for (int k = 0; k < NUM_WB; k++) begin
                io.IN_wbValid[k] = ($urandom_range(0, 99) < 15);
                io.IN_wbTag[k*(TAG_W-1) +: (TAG_W-1)] = 6'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 99) < 4) begin
                io.IN_brTaken    = 1'b1;
                io.IN_brFlush    = ($urandom_range(0, 3) == 0);
                io.IN_brStoreSqN = next_sqn - 7'($urandom_range(1, 10));
            end
            tick();
            if (io.IN_brTaken && !io.IN_brFlush) next_sqn = io.IN_brStoreSqN + 7'd1;
            checks++;
            if (io.OUT_valid !== m_out_v) begin
                errors++; $display("FAIL rand_valid cyc %0d: got %b expected %b", c, io.OUT_valid, m_out_v);
            end
            if (m_out_v) begin
                checks++;
                if (io.OUT_tag !== m_out.tag || io.OUT_storeSqN !== m_out.sqn || io.OUT_offs !== m_out.offs) begin
                    errors++; $display("FAIL rand_payload cyc %0d: got %h/%0d/%0d expected %h/%0d/%0d", c,
                                       io.OUT_tag, io.OUT_storeSqN, io.OUT_offs, m_out.tag, m_out.sqn, m_out.offs);
                end
            end
            checks++;
            if (io.OUT_enqReady !== (mq.size() < DEPTH)) begin
                errors++; $display("FAIL rand_ready cyc %0d: got %b expected %b (model count %0d)",
                                   c, io.OUT_enqReady, (mq.size() < DEPTH), mq.size());
            end
        end
    endtask

    initial begin
        idle_inputs();
        io.IN_outReady = 1'b1;
        test_reset();
        test_immediate();
        test_wakeup_order();
        test_full();
        test_branch_kill();
        test_wraparound();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
